// File: rtl/tuner_ctrl.sv
// rtl/tuner_ctrl.sv - FM tuning controller producing the DDS phase-increment word K
// Optional key auto-repeat is built when TUNER_AUTOREPEAT_EN is defined.
module tuner_ctrl #(
    parameter int          WIDTH_DDS    = 32,
    parameter int          WIDTH_CH     = 8,
    parameter int          N_CHAN       = 206,
    parameter int unsigned K_MIN        = 32'd1565873493,
    parameter int unsigned K_STEP       = 32'd1789570,
    parameter int          RESET_CHAN   = 125,
    parameter int          DEBOUNCE     = 240000,
    parameter int          REPEAT_DELAY = 12000000,
    parameter int          REPEAT_RATE  = 2400000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 key_up_n,
    input  logic                 key_down_n,
    input  logic                 preset_load,
    input  logic [WIDTH_CH-1:0]  preset_ch,
    output logic [WIDTH_DDS-1:0] K,
    output logic [WIDTH_CH-1:0]  chan,
    output logic                 k_update,
    output logic                 busy
);

    localparam int CNT_MAX0 = (DEBOUNCE > REPEAT_DELAY) ? DEBOUNCE : REPEAT_DELAY;
    localparam int CNT_MAX  = (CNT_MAX0 > REPEAT_RATE) ? CNT_MAX0 : REPEAT_RATE;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int BC_W     = $clog2(WIDTH_CH + 1);

    localparam logic [WIDTH_DDS-1:0] LP_K_MIN  = WIDTH_DDS'(K_MIN);
    localparam logic [WIDTH_DDS-1:0] LP_K_STEP = WIDTH_DDS'(K_STEP);
    localparam logic [WIDTH_DDS-1:0] LP_K_TOP  = WIDTH_DDS'(K_MIN + K_STEP * (N_CHAN - 1));
    localparam logic [WIDTH_DDS-1:0] LP_K_RST  = WIDTH_DDS'(K_MIN + K_STEP * RESET_CHAN);
    localparam logic [WIDTH_DDS-1:0] LP_MCAND0 = LP_K_STEP << (WIDTH_CH - 1);
    localparam logic [WIDTH_CH-1:0]  LP_CH_TOP = WIDTH_CH'(N_CHAN - 1);
    localparam logic [WIDTH_CH-1:0]  LP_CH_RST = WIDTH_CH'(RESET_CHAN);
    localparam logic [WIDTH_CH-1:0]  LP_CH_ONE = WIDTH_CH'(1);
    localparam logic [CNT_W-1:0]     LP_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]     LP_DB_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [BC_W-1:0]      LP_BIT_LAST = BC_W'(WIDTH_CH - 1);

    // index 0 = up key, index 1 = down key; all key signals are active-high "pressed"
    logic [1:0] w_press_raw;
    logic [1:0] w_deb;
    logic [1:0] w_evt;

    assign w_press_raw = {~key_down_n, ~key_up_n};

    for (genvar g = 0; g < 2; g++) begin : g_key
        logic [1:0]       r_sync;
        logic             r_deb;
        logic             r_evt;
        logic [CNT_W-1:0] r_db_cnt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_sync   <= 2'b00;
                r_deb    <= 1'b0;
                r_evt    <= 1'b0;
                r_db_cnt <= '0;
            end else begin
                r_sync <= {r_sync[0], w_press_raw[g]};
                r_evt  <= 1'b0;
                if (r_sync[1] == r_deb) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == LP_DB_LAST) begin
                    r_db_cnt <= '0;
                    r_deb    <= r_sync[1];
                    r_evt    <= r_sync[1];
                end else begin
                    r_db_cnt <= r_db_cnt + LP_CNT_ONE;
                end
            end
        end

`ifdef TUNER_AUTOREPEAT_EN
        localparam logic [CNT_W-1:0] LP_DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
        localparam logic [CNT_W-1:0] LP_RATE_LAST = CNT_W'(REPEAT_RATE - 1);
        logic [CNT_W-1:0] r_rep_cnt;
        logic             r_rep_run;
        logic             r_rep_evt;

        // first repeat after the long delay, then at the faster rate until release
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_rep_cnt <= '0;
                r_rep_run <= 1'b0;
                r_rep_evt <= 1'b0;
            end else begin
                r_rep_evt <= 1'b0;
                if (!r_deb) begin
                    r_rep_cnt <= '0;
                    r_rep_run <= 1'b0;
                end else if (r_rep_cnt == (r_rep_run ? LP_RATE_LAST : LP_DLY_LAST)) begin
                    r_rep_cnt <= '0;
                    r_rep_run <= 1'b1;
                    r_rep_evt <= 1'b1;
                end else begin
                    r_rep_cnt <= r_rep_cnt + LP_CNT_ONE;
                end
            end
        end

        assign w_evt[g] = r_evt | r_rep_evt;
`else
        assign w_evt[g] = r_evt;
`endif
        assign w_deb[g] = r_deb;
    end

    // a key only steps while the opposite key is released
    logic w_step_up;
    logic w_step_dn;
    logic [WIDTH_CH-1:0] w_ch_clamp;

    assign w_step_up  = w_evt[0] & ~w_deb[1];
    assign w_step_dn  = w_evt[1] & ~w_deb[0];
    assign w_ch_clamp = (preset_ch > LP_CH_TOP) ? LP_CH_TOP : preset_ch;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_UPDATE} state_t;

    state_t               r_state;
    logic [WIDTH_DDS-1:0] r_acc;
    logic [WIDTH_DDS-1:0] r_mcand;
    logic [WIDTH_CH-1:0]  r_mplier;
    logic [WIDTH_CH-1:0]  r_ch_tgt;
    logic [BC_W-1:0]      r_bit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            K        <= LP_K_RST;
            chan     <= LP_CH_RST;
            k_update <= 1'b0;
            busy     <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_ch_tgt <= '0;
            r_bit    <= '0;
        end else begin
            k_update <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (preset_load) begin
                        r_state  <= S_CALC;
                        busy     <= 1'b1;
                        r_acc    <= LP_K_MIN;
                        r_mcand  <= LP_MCAND0;
                        r_mplier <= w_ch_clamp;
                        r_ch_tgt <= w_ch_clamp;
                        r_bit    <= '0;
                    end else if (w_step_up) begin
                        k_update <= 1'b1;
                        if (chan == LP_CH_TOP) begin
                            chan <= '0;
                            K    <= LP_K_MIN;
                        end else begin
                            chan <= chan + LP_CH_ONE;
                            K    <= K + LP_K_STEP;
                        end
                    end else if (w_step_dn) begin
                        k_update <= 1'b1;
                        if (chan == '0) begin
                            chan <= LP_CH_TOP;
                            K    <= LP_K_TOP;
                        end else begin
                            chan <= chan - LP_CH_ONE;
                            K    <= K - LP_K_STEP;
                        end
                    end
                end
                // MSB-first: the addend starts at K_STEP scaled by the top bit weight
                S_CALC: begin
                    if (r_mplier[WIDTH_CH-1]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mplier <= r_mplier << 1;
                    r_mcand  <= r_mcand >> 1;
                    r_bit    <= r_bit + BC_W'(1);
                    if (r_bit == LP_BIT_LAST) begin
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    K        <= r_acc;
                    chan     <= r_ch_tgt;
                    k_update <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tuner_ctrl.sv
// tb/tb_tuner_ctrl.sv - self-checking bench for tuner_ctrl
module tb_tuner_ctrl;

    localparam int     D    = 4;
    localparam int     RD   = 20;
    localparam int     RR   = 5;
    localparam int     NCH  = 206;
    localparam longint KMIN = 1565873493;
    localparam longint KSTEP = 1789570;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        key_up_n;
    logic        key_down_n;
    logic        preset_load;
    logic [7:0]  preset_ch;
    logic [31:0] K;
    logic [7:0]  chan;
    logic        k_update;
    logic        busy;

    tuner_ctrl #(
        .DEBOUNCE    (D),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_up_n   (key_up_n),
        .key_down_n (key_down_n),
        .preset_load(preset_load),
        .preset_ch  (preset_ch),
        .K          (K),
        .chan       (chan),
        .k_update   (k_update),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int upd_q[$];
    always @(negedge clk) if (k_update === 1'b1) upd_q.push_back(cyc);

    int n_assert = 0;
    int n_fail   = 0;
    int m_chan;

    function automatic logic [63:0] k_of(input int ch);
        longint v;
        v = KMIN + longint'(ch) * KSTEP;
        return 64'(v) & 64'hFFFF_FFFF;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_chan"}, 64'(chan), 64'(m_chan));
        check({tag, "_K"}, 64'(K), k_of(m_chan));
    endtask

    task automatic key_step(input bit up, input string tag);
        int p;
        upd_q.delete();
        p = cyc;
        if (up) key_up_n = 1'b0; else key_down_n = 1'b0;
        tick(10);
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        tick(10);
        m_chan = up ? (m_chan + 1) % NCH : (m_chan + NCH - 1) % NCH;
        check({tag, "_nupd"}, 64'(upd_q.size()), 64'(1));
        check({tag, "_when"}, 64'(upd_q.size() > 0 ? upd_q[0] : -1), 64'(p + 2 + D + 1));
        check_state(tag);
    endtask

    task automatic do_preset(input int ch, input string tag);
        int a;
        upd_q.delete();
        preset_ch   = 8'(ch);
        preset_load = 1'b1;
        a = cyc + 1;
        tick(1);
        preset_load = 1'b0;
        check({tag, "_busy_first"}, 64'(busy), 64'(1));
        tick(8);
        check({tag, "_busy_last"}, 64'(busy), 64'(1));
        check({tag, "_noupd_early"}, 64'(k_update), 64'(0));
        tick(1);
        check({tag, "_busy_done"}, 64'(busy), 64'(0));
        check({tag, "_strobe"}, 64'(k_update), 64'(1));
        m_chan = (ch > NCH - 1) ? NCH - 1 : ch;
        check_state(tag);
        tick(3);
        check({tag, "_nupd"}, 64'(upd_q.size()), 64'(1));
        check({tag, "_when"}, 64'(upd_q.size() > 0 ? upd_q[0] : -1), 64'(a + 9));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int q;
        int nexp;
        reset_n     = 1'b0;
        key_up_n    = 1'b1;
        key_down_n  = 1'b1;
        preset_load = 1'b0;
        preset_ch   = 8'd0;
        m_chan      = 125;

        tick(3);
        check("rst_chan", 64'(chan), 64'(125));
        check("rst_K", 64'(K), 64'(1789569743));
        check("rst_kupd", 64'(k_update), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        reset_n = 1'b1;
        tick(3);
        check_state("after_rst");
        check("after_rst_busy", 64'(busy), 64'(0));

        // bouncing press, then stable
        upd_q.delete();
        for (int i = 0; i < 3; i++) begin
            key_up_n = 1'b0;
            tick(1);
            key_up_n = 1'b1;
            tick(1);
        end
        key_up_n = 1'b0;
        q = cyc;
        tick(10);
        key_up_n = 1'b1;
        tick(10);
        m_chan = 126;
        check("bounce_nupd", 64'(upd_q.size()), 64'(1));
        check("bounce_when", 64'(upd_q.size() > 0 ? upd_q[0] : -1), 64'(q + 2 + D + 1));
        check("bounce_K", 64'(K), 64'(1791359313));
        check_state("bounce");

        do_preset(205, "preset205");
        check("preset205_Kabs", 64'(K), 64'(1932735343));
        key_step(1'b1, "wrap_up");
        check("wrap_up_chan0", 64'(chan), 64'(0));
        key_step(1'b0, "wrap_dn");
        check("wrap_dn_chan205", 64'(chan), 64'(205));
        key_step(1'b0, "dn_204");

        // clamped preset with a key event and a second preset arriving while busy
        upd_q.delete();
        p = cyc;
        key_down_n = 1'b0;
        tick(2);
        preset_ch   = 8'd250;
        preset_load = 1'b1;
        tick(1);
        preset_load = 1'b0;
        tick(3);
        preset_ch   = 8'd17;
        preset_load = 1'b1;
        tick(1);
        preset_load = 1'b0;
        tick(6);
        key_down_n = 1'b1;
        tick(14);
        m_chan = 205;
        check("busy_drop_nupd", 64'(upd_q.size()), 64'(1));
        check("busy_drop_when", 64'(upd_q.size() > 0 ? upd_q[0] : -1), 64'(p + 3 + 9));
        check_state("busy_drop");

        // both keys together
        upd_q.delete();
        key_up_n   = 1'b0;
        key_down_n = 1'b0;
        tick(10);
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        tick(12);
        check("both_nupd", 64'(upd_q.size()), 64'(0));
        check_state("both");

        // reset in the middle of a preset calculation
        upd_q.delete();
        preset_ch   = 8'd40;
        preset_load = 1'b1;
        tick(1);
        preset_load = 1'b0;
        tick(4);
        reset_n = 1'b0;
        #1;
        m_chan = 125;
        check("midcalc_busy", 64'(busy), 64'(0));
        check_state("midcalc_async");
        tick(2);
        reset_n = 1'b1;
        tick(15);
        check("midcalc_nupd", 64'(upd_q.size()), 64'(0));
        check_state("midcalc_after");

        // long hold: auto-repeat when built, a single step otherwise
        upd_q.delete();
        p = cyc;
        key_up_n = 1'b0;
        tick(38);
        key_up_n = 1'b1;
        tick(30);
`ifdef TUNER_AUTOREPEAT_EN
        nexp = 5;
`else
        nexp = 1;
`endif
        check("hold_nupd", 64'(upd_q.size()), 64'(nexp));
        for (int i = 0; i < nexp; i++) begin
            int exp_t;
            exp_t = (i == 0) ? p + 2 + D + 1 : p + 2 + D + 1 + RD + (i - 1) * RR;
            check($sformatf("hold_when%0d", i), 64'(upd_q.size() > i ? upd_q[i] : -1), 64'(exp_t));
        end
        m_chan = (m_chan + nexp) % NCH;
        check_state("hold");

        // random mix of presets and steps against the channel model
        for (int i = 0; i < 12; i++) begin
            int op;
            op = int'($urandom_range(0, 2));
            if (op == 0) do_preset(int'($urandom_range(0, 255)), $sformatf("rnd%0d_preset", i));
            else key_step(op == 1, $sformatf("rnd%0d_step", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tuner_ctrl.md
# tuner_ctrl

FM tuning controller that turns user step requests and channel presets into the DDS phase-increment word `K` driving the radio core's mixer NCO. It debounces up/down tuning keys, tracks the current channel inside the 87.5–108 MHz band at 100 kHz spacing, wraps at band edges, and computes `K` incrementally for steps and by shift-add multiplication for presets. It sits in the slow control clock domain between the board pushbuttons/switches and the radio core's `K` input.

## Interface
- `WIDTH_DDS`, 32, width of `K`
- `WIDTH_CH`, 8, width of channel index
- `N_CHAN`, 206, number of channels (0..N_CHAN-1)
- `K_MIN`, 1565873493, `K` of channel 0 (87.5 MHz at 240 MHz sample clock)
- `K_STEP`, 1789570, `K` increment per channel (100 kHz)
- `RESET_CHAN`, 125, channel after reset (100.0 MHz)
- `DEBOUNCE`, 240000, cycles a key must be stable to register
- `REPEAT_DELAY`, 12000000, hold time before auto-repeat starts
- `REPEAT_RATE`, 2400000, cycles between auto-repeat steps

Ports:
- `clk` input 1 control clock
- `reset_n` input 1 asynchronous active-low reset
- `key_up_n` input 1 raw pushbutton, active low, asynchronous
- `key_down_n` input 1 raw pushbutton, active low, asynchronous
- `preset_load` input 1 single-cycle request to jump to `preset_ch`
- `preset_ch` input WIDTH_CH preset channel, sampled with `preset_load`
- `K` output WIDTH_DDS phase increment to radio core
- `chan` output WIDTH_CH current channel index
- `k_update` output 1 one-cycle strobe: `K`/`chan` just changed
- `busy` output 1 preset calculation in progress

## Operation
- Keys pass through 2-flop synchronizers, then a per-key debounce counter; debounced state changes only after `DEBOUNCE` consecutive equal samples.
- A step event is a debounced press edge. Both keys pressed simultaneously: no event from either.
- States: IDLE, CALC, UPDATE.
- IDLE: `preset_load` has priority over a step event in the same cycle.
- Step up: `chan` = chan+1, `K` += `K_STEP`; at `chan` = N_CHAN-1 wraps to 0, `K` = `K_MIN`.
- Step down: `chan` = chan-1, `K` -= `K_STEP`; at 0 wraps to N_CHAN-1, `K` = `K_MIN` + (N_CHAN-1)·`K_STEP` (elaboration constant).
- Preset: `preset_ch` ≥ N_CHAN is clamped to N_CHAN-1. IDLE→CALC; shift-add multiply `preset_ch`·`K_STEP` over WIDTH_CH cycles (MSB first) into a WIDTH_DDS accumulator seeded with `K_MIN`; CALC→UPDATE; UPDATE loads `K`/`chan`, pulses `k_update`, returns to IDLE.
- Step events and `preset_load` arriving during CALC/UPDATE are dropped.
- All arithmetic modulo 2^WIDTH_DDS; `K` never exceeds the band-top value by construction.

## Timing
- Reset values: `chan` = `RESET_CHAN`, `K` = `K_MIN` + `RESET_CHAN`·`K_STEP` (constant), `k_update` = 0, `busy` = 0, state IDLE, debounced keys released, repeat counters 0.
- Key press to `k_update`: 2 (sync) + `DEBOUNCE` + 1 cycles; `K`/`chan` change in the same cycle `k_update` is high.
- Preset: `preset_load` in cycle t → `busy` high t+1..t+WIDTH_CH+1, `k_update` with new `K` at t+WIDTH_CH+2.
- `K` stable between `k_update` strobes (consumer in 240 MHz domain samples after the strobe via its own synchronizer).
- Reset mid-CALC: immediate abort, reset values restored, no `k_update`.

## Configuration
- `TUNER_AUTOREPEAT_EN` defined: a key held debounced-pressed for `REPEAT_DELAY` cycles generates one step, then one further step every `REPEAT_RATE` cycles until release; both keys held suppresses repeats.
- Not defined: exactly one step per press; repeat counters not built.

## Test plan
(Bench uses `DEBOUNCE`=4, `REPEAT_DELAY`=20, `REPEAT_RATE`=5.)
- Release reset → `chan`=125, `K`=1789569743, `k_update`=0, `busy`=0.
- Press `key_up_n` with 3-cycle bounce glitches, then hold stable → exactly one `k_update`, `chan`=126, `K`=1791359313.
- `preset_load` with `preset_ch`=205, then step up → `K`=1565873493+205·1789570=1932735343 after 10 cycles; step wraps to `chan`=0, `K`=1565873493; step down wraps back to 205.
- `preset_ch`=250 → clamped, `chan`=205; step event during `busy` → ignored, single `k_update`.
- Both keys pressed together → no `k_update`; assert `reset_n` low during CALC → reset values, no strobe.
- With `TUNER_AUTOREPEAT_EN`: hold up 40 cycles after debounce → steps at debounce+1, +20, +25, +30, +35 (5 total); without macro → 1 step.
